// File: rtl/backend_types.sv
// Shared back-end sizing and types for the rename free list.
package backend_types;

  localparam int unsigned NUM_PHYS_REGS      = 64;
  localparam int unsigned NUM_ARCH_REGISTERS = 32;
  localparam int unsigned PHYS_REG_WIDTH     = $clog2(NUM_PHYS_REGS);
  localparam int unsigned BRB_DEPTH          = 4;
  localparam int unsigned FL_DEPTH           = NUM_PHYS_REGS - NUM_ARCH_REGISTERS;
  localparam int unsigned FL_PTR_W           = $clog2(FL_DEPTH) + 1;

  // MSB is the wrap bit, the rest index the free-list storage.
  typedef logic [FL_PTR_W-1:0]       fl_ptr_t;
  typedef logic [PHYS_REG_WIDTH-1:0] preg_t;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers with head checkpoint/restore.
// Optional branch checkpoint array enabled by macro FREE_LIST_CKPT_EN.
module free_list #(
  parameter int unsigned NUM_PHYS_REGS      = backend_types::NUM_PHYS_REGS,
  parameter int unsigned NUM_ARCH_REGISTERS = backend_types::NUM_ARCH_REGISTERS,
  parameter int unsigned BRB_DEPTH          = backend_types::BRB_DEPTH,
  localparam int unsigned FL_DEPTH          = NUM_PHYS_REGS - NUM_ARCH_REGISTERS,
  localparam int unsigned PHYS_REG_WIDTH    = $clog2(NUM_PHYS_REGS),
  localparam int unsigned PTR_W             = $clog2(FL_DEPTH) + 1,
  localparam int unsigned TAG_W             = (BRB_DEPTH > 1) ? $clog2(BRB_DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      deq_req,
  output logic                      deq_valid,
  output logic [PHYS_REG_WIDTH-1:0] deq_rdata,
  input  logic                      enq_valid,
  input  logic [PHYS_REG_WIDTH-1:0] enq_wdata,
  input  logic                      ckpt_valid,
  input  logic [TAG_W-1:0]          ckpt_tag,
  input  logic                      kill,
  input  logic [TAG_W-1:0]          kill_tag,
  output logic [PTR_W-1:0]          free_count
);

  localparam int unsigned IDX_W = PTR_W - 1;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [PHYS_REG_WIDTH-1:0] mem_q [FL_DEPTH];
  ptr_t head_q, head_d, head_inc;
  ptr_t tail_q, tail_d, tail_inc;
  logic full, do_deq, do_enq;

  // Index wraps at FL_DEPTH-1, which need not be a power of two.
  function automatic ptr_t ptr_inc(ptr_t p);
    ptr_t r;
    if (p[IDX_W-1:0] == IDX_W'(FL_DEPTH - 1)) begin
      r = {~p[PTR_W-1], {IDX_W{1'b0}}};
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  always_comb begin
    free_count = {1'b0, tail_q[IDX_W-1:0]} - {1'b0, head_q[IDX_W-1:0]};
    if (head_q[PTR_W-1] != tail_q[PTR_W-1]) begin
      free_count = free_count + PTR_W'(FL_DEPTH);
    end
    full      = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                (head_q[PTR_W-1] != tail_q[PTR_W-1]);
    deq_valid = (free_count != '0);
    deq_rdata = mem_q[head_q[IDX_W-1:0]];
  end

`ifdef FREE_LIST_CKPT_EN
  ptr_t ckpt_q [BRB_DEPTH];
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{ckpt_valid, ckpt_tag, kill_tag};
`endif

  always_comb begin
    head_inc = ptr_inc(head_q);
    tail_inc = ptr_inc(tail_q);
    do_deq   = deq_req && deq_valid && !kill;
    do_enq   = enq_valid && (enq_wdata != '0) && !full;
    tail_d   = do_enq ? tail_inc : tail_q;
    head_d   = do_deq ? head_inc : head_q;
    if (kill) begin
`ifdef FREE_LIST_CKPT_EN
      head_d = ckpt_q[kill_tag];
`else
      // Full flush: everything committed up to tail_d is free again.
      head_d = {~tail_d[PTR_W-1], tail_d[IDX_W-1:0]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= {1'b1, {IDX_W{1'b0}}};
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= PHYS_REG_WIDTH'(NUM_ARCH_REGISTERS + i);
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (do_enq) begin
        mem_q[tail_q[IDX_W-1:0]] <= enq_wdata;
      end
    end
  end

`ifdef FREE_LIST_CKPT_EN
  // Snapshot is the post-dequeue head so the branch's own dest preg stays allocated.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BRB_DEPTH; i++) begin
        ckpt_q[i] <= '0;
      end
    end else if (ckpt_valid && !kill) begin
      ckpt_q[ckpt_tag] <= head_d;
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: fixed vectors, corner sequences, random vs model.
module tb_free_list;
  import backend_types::*;

  localparam int FL = int'(FL_DEPTH);
  localparam int NA = int'(NUM_ARCH_REGISTERS);
  localparam int NB = int'(BRB_DEPTH);

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      deq_req, deq_valid, enq_valid, ckpt_valid, kill;
  logic [PHYS_REG_WIDTH-1:0] deq_rdata, enq_wdata;
  logic [1:0]                ckpt_tag, kill_tag;
  logic [FL_PTR_W-1:0]       free_count;

  free_list dut (
    .clk        (clk),
    .rst        (rst),
    .deq_req    (deq_req),
    .deq_valid  (deq_valid),
    .deq_rdata  (deq_rdata),
    .enq_valid  (enq_valid),
    .enq_wdata  (enq_wdata),
    .ckpt_valid (ckpt_valid),
    .ckpt_tag   (ckpt_tag),
    .kill       (kill),
    .kill_tag   (kill_tag),
    .free_count (free_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: unbounded dequeue/enqueue counts and a plain storage array.
  int m_head, m_tail;
  int m_mem  [FL];
  int m_ckpt [NB];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_head = 0;
    m_tail = FL;
    for (int i = 0; i < FL; i++) m_mem[i] = NA + i;
    for (int i = 0; i < NB; i++) m_ckpt[i] = 0;
  endfunction

  function automatic void model_step(bit d, bit ev, int wd, bit cv, int ct, bit k, int kt);
    int  free = m_tail - m_head;
    bit  en   = ev && (wd != 0) && (free < FL);
    bit  dq   = d && (free != 0) && !k;
    int  nt   = m_tail + (en ? 1 : 0);
    if (en) m_mem[m_tail % FL] = wd;
    if (k) begin
`ifdef FREE_LIST_CKPT_EN
      m_head = m_ckpt[kt];
`else
      m_head = nt - FL;
`endif
    end else begin
      if (dq) m_head++;
      if (cv) m_ckpt[ct] = m_head;
    end
    m_tail = nt;
  endfunction

  task automatic idle_inputs();
    deq_req = 0; enq_valid = 0; enq_wdata = '0;
    ckpt_valid = 0; ckpt_tag = '0; kill = 0; kill_tag = '0;
  endtask

  task automatic cyc(bit d, bit ev, int wd, bit cv, int ct, bit k, int kt);
    deq_req = d; enq_valid = ev; enq_wdata = PHYS_REG_WIDTH'(wd);
    ckpt_valid = cv; ckpt_tag = 2'(ct); kill = k; kill_tag = 2'(kt);
    model_step(d, ev, wd, cv, ct, k, kt);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic check_state(string name, int v, int rd, int fc);
    check({name, ".deq_valid"}, int'(deq_valid), v);
    check({name, ".deq_rdata"}, int'(deq_rdata), rd);
    check({name, ".free_count"}, int'(free_count), fc);
  endtask

  task automatic check_model(string name);
    int fc = m_tail - m_head;
    check({name, ".free_count"}, int'(free_count), fc);
    check({name, ".deq_valid"}, int'(deq_valid), (fc != 0) ? 1 : 0);
    check({name, ".deq_rdata"}, int'(deq_rdata), m_mem[m_head % FL]);
  endtask

  typedef struct {
    bit deq;
    bit enq;
    int wdata;
    int exp_valid;
    int exp_rdata;
    int exp_count;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{deq: 0, enq: 1, wdata: 5, exp_valid: 1, exp_rdata: 32, exp_count: 32};
    vecs[1] = '{deq: 1, enq: 0, wdata: 0, exp_valid: 1, exp_rdata: 33, exp_count: 31};
    vecs[2] = '{deq: 1, enq: 1, wdata: 0, exp_valid: 1, exp_rdata: 34, exp_count: 30};
    vecs[3] = '{deq: 0, enq: 1, wdata: 7, exp_valid: 1, exp_rdata: 34, exp_count: 31};
    vecs[4] = '{deq: 1, enq: 1, wdata: 9, exp_valid: 1, exp_rdata: 35, exp_count: 31};
    vecs[5] = '{deq: 0, enq: 0, wdata: 0, exp_valid: 1, exp_rdata: 35, exp_count: 31};

    idle_inputs();
    rst = 1;
    #2;
    do_reset();
    check_state("reset", 1, 32, 32);

    // Fixed vectors: full-list drop, preg-0 drop, simultaneous enq/deq.
    foreach (vecs[i]) begin
      cyc(vecs[i].deq, vecs[i].enq, vecs[i].wdata, 0, 0, 0, 0);
      check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_rdata,
                  vecs[i].exp_count);
    end

    // Drain the whole list in order.
    do_reset();
    for (int i = 0; i < FL; i++) begin
      check($sformatf("drain%0d.deq_rdata", i), int'(deq_rdata), NA + i);
      cyc(1, 0, 0, 0, 0, 0, 0);
    end
    check_state("drained", 0, int'(deq_rdata), 0);

    // Empty list: no enq-to-deq bypass.
    deq_req = 1; enq_valid = 1; enq_wdata = PHYS_REG_WIDTH'(40);
    #1;
    check("empty_bypass.deq_valid", int'(deq_valid), 0);
    cyc(1, 1, 40, 0, 0, 0, 0);
    check_state("empty_enq", 1, 40, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("enq_zero.free_count", int'(free_count), 1);

    // Reset dominates kill/enq/deq; checkpoints cleared to zero.
    rst = 1; deq_req = 1; enq_valid = 1; enq_wdata = PHYS_REG_WIDTH'(10); kill = 1;
    @(posedge clk);
    #1;
    rst = 0;
    idle_inputs();
    model_reset();
    check_state("rst_dominates", 1, 32, 32);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    check_state("kill_after_reset", 1, 32, 32);

`ifdef FREE_LIST_CKPT_EN
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    check_state("pre_kill", 1, 41, 23);
    cyc(0, 0, 0, 0, 0, 1, 2);
    check_state("kill_restore", 1, 36, 28);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 50, 1, 3, 1, 2);
    check_state("kill_enq_deq", 1, 36, 29);
    for (int i = 0; i < 28; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    check_state("enq50_reached", 1, 50, 1);
`else
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0, 0);
    check("flush_pre.free_count", int'(free_count), 23);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check_state("flush", 1, 33, 32);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 50, 1, 1, 1, 0);
    check_state("flush_enq_deq", 1, 34, 32);
`endif

    // Randomised traffic against the model, many wraps of both pointers.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit d  = ($urandom_range(0, 9) < 6);
      bit ev = ($urandom_range(0, 1) == 1);
      int wd = int'($urandom_range(0, 63));
      bit cv = ($urandom_range(0, 4) == 0);
      int ct = int'($urandom_range(0, NB - 1));
      bit k  = ($urandom_range(0, 19) == 0);
      int kt = int'($urandom_range(0, NB - 1));
`ifdef FREE_LIST_CKPT_EN
      begin
        int nt = m_tail + ((ev && wd != 0 && (m_tail - m_head) < FL) ? 1 : 0);
        // Only restore checkpoints that still describe a legal head.
        if (nt - m_ckpt[kt] < 0 || nt - m_ckpt[kt] > FL) k = 0;
      end
`endif
      cyc(d, ev, wd, cv, ct, k, kt);
      check_model($sformatf("rand%0d", n));
      if (int'(free_count) > FL) begin
        n_fail++;
        $display("FAIL rand%0d.bound: free_count %0d exceeds %0d", n, free_count, FL);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter NUM_PHYS_REGS, default 64: total physical registers.
REQ-002 Parameter NUM_ARCH_REGISTERS, default 32: architectural registers, identity-mapped at reset.
REQ-003 Parameter BRB_DEPTH, default 4: branch checkpoint slots, tag width $clog2(BRB_DEPTH).
REQ-004 Derived: FL_DEPTH = NUM_PHYS_REGS-NUM_ARCH_REGISTERS; PHYS_REG_WIDTH = $clog2(NUM_PHYS_REGS); PTR_W = $clog2(FL_DEPTH)+1, where the MSB is the wrap bit.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 deq_req  input  1  rename consumes one free preg this cycle.
REQ-008 deq_valid  output  1  list non-empty; deq_rdata is meaningful.
REQ-009 deq_rdata  output  PHYS_REG_WIDTH  preg at head, combinational read.
REQ-010 enq_valid  input  1  commit returns a stale preg.
REQ-011 enq_wdata  input  PHYS_REG_WIDTH  preg being freed.
REQ-012 ckpt_valid  input  1  branch renamed this cycle; snapshot the head.
REQ-013 ckpt_tag  input  tag width  checkpoint slot to write.
REQ-014 kill  input  1  mispredict recovery request.
REQ-015 kill_tag  input  tag width  checkpoint slot to restore.
REQ-016 free_count  output  PTR_W  number of free entries (tail-head, modulo wrap).

Function
REQ-017 Storage SHALL be a circular FIFO of FL_DEPTH preg indices with head/tail pointers of PTR_W bits; empty = pointers equal, full = indices equal and wrap bits differ.
REQ-018 deq_valid SHALL equal (free_count != 0) with zero-cycle latency; deq_rdata SHALL equal mem[head index] at all times.
REQ-019 deq_req with deq_valid=1 SHALL advance head by one at the next edge; deq_req with deq_valid=0 SHALL be ignored with no pointer change.
REQ-020 enq_valid with enq_wdata!=0 and not full SHALL write mem[tail] and advance tail; enq of preg 0 SHALL be dropped; enq while full SHALL be dropped.
REQ-021 Simultaneous enq and deq SHALL both take effect in the same cycle; there is no enq-to-deq bypass when the list is empty, so deq_valid stays 0 that cycle.
REQ-022 Pointer increments SHALL wrap index FL_DEPTH-1 to 0 and toggle the wrap bit.
REQ-023 The ckpt_valid snapshot SHALL store the post-dequeue head, i.e. head+1 if a dequeue occurs the same cycle, otherwise head.
REQ-024 kill SHALL restore head from the selected source at the next edge and SHALL suppress any same-cycle deq_req and ckpt_valid.
REQ-025 enq_valid SHALL still take effect in a kill cycle, because commit is non-speculative.
REQ-026 Tail SHALL never be changed by kill.

Reset
REQ-027 On rst: mem[i] = NUM_ARCH_REGISTERS+i for i in 0..FL_DEPTH-1, head = 0, tail = {1'b1, 0} (full), free_count = FL_DEPTH, deq_valid = 1, deq_rdata = NUM_ARCH_REGISTERS.
REQ-028 On rst: all checkpoint slots = 0.
REQ-029 rst SHALL dominate kill, enq and deq in the same cycle.

Configuration
REQ-030 With macro FREE_LIST_CKPT_EN defined:
- a BRB_DEPTH x PTR_W checkpoint array exists;
- kill restores head from ckpt[kill_tag].
REQ-031 Without FREE_LIST_CKPT_EN:
- no checkpoint array exists;
- ckpt_valid, ckpt_tag and kill_tag are ignored;
- kill is a commit-point full flush that sets head = tail - FL_DEPTH, giving free_count = FL_DEPTH on the next cycle.

Structure
REQ-032 NUM_PHYS_REGS, NUM_ARCH_REGISTERS, PHYS_REG_WIDTH, BRB_DEPTH and the free-list pointer typedef SHALL live in backend_types.
REQ-033 The block SHALL be a single module; no sub-module is required.

Verification
REQ-034 Reset then 32 back-to-back deq_req: deq_rdata = 32,33,...,63; after the last, deq_valid = 0 and free_count = 0.
REQ-035 Empty list, deq_req=1 and enq 40 in the same cycle: no dequeue; next cycle deq_valid = 1, deq_rdata = 40, free_count = 1.
REQ-036 Full list, enq 5: dropped, free_count stays 32; enq 0 on a non-full list: dropped, tail unchanged.
REQ-037 CKPT_EN: deq 3, checkpoint tag 2 together with a 4th deq, deq 5 more, then kill tag 2: head = 4, deq_rdata = 36, free_count = 28.
REQ-038 Kill with concurrent deq_req and enq 50: deq suppressed, 50 written at tail, free_count reflects both the restore and +1.
REQ-039 No CKPT_EN: deq 10, enq 2, then kill: free_count = 32 next cycle; 40 wrap cycles of deq/enq hold pointer consistency (free_count never exceeds 32).
